// File: rtl/txn_ring_buffer.sv
// Transactional ring buffer over an external memory: pushes are staged behind
// wr_tmp and only become visible to pop once committed.
module txn_ring_buffer #(
  parameter int DATAW = 16,
  parameter int ADDRW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_request,
  input  logic [DATAW-1:0] push_data,
  output logic             push_done,
  input  logic             pop_request,
  output logic [DATAW-1:0] pop_data,
  output logic             pop_done,
  input  logic             open,
  input  logic             commit,
  input  logic             rollback,
  output logic             wr_request,
  output logic [ADDRW-1:0] wr_addr,
  output logic [DATAW-1:0] wr_data,
  input  logic             wr_done,
  output logic             rd_request,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [DATAW-1:0] rd_data,
  input  logic             rd_done,
  output logic [ADDRW:0]   count,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DONE_W, DONE_R} state_t;

  localparam logic [ADDRW:0] DEPTH = {1'b1, {ADDRW{1'b0}}};
  localparam logic [ADDRW:0] ONE   = {{ADDRW{1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [ADDRW:0]   rd_ptr, wr_ptr, wr_tmp;
  logic [ADDRW:0]   wr_ptr_ctrl, wr_tmp_ctrl;
  logic             pend_push, pend_pop, pend_open, pend_commit, pend_rollback;
  logic [DATAW-1:0] push_buf;
  logic [DATAW-1:0] wr_data_q, pop_data_q;
  logic [ADDRW-1:0] wr_addr_q, rd_addr_q;
  logic             overflow_q, underflow_q;
  logic             is_empty, is_full, ctrl_any;
  logic             do_ctrl, do_push, do_pop;

  assign is_empty = (rd_ptr == wr_ptr);
  assign is_full  = ((wr_tmp - rd_ptr) == DEPTH);
  assign ctrl_any = pend_open | pend_commit | pend_rollback;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // IDLE arbitration: control beats push beats pop, one action per cycle.
  always_comb begin
    state_nxt = state;
    do_ctrl   = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_any) begin
          do_ctrl = 1'b1;
        end else if (pend_push) begin
          do_push   = 1'b1;
          state_nxt = is_full ? DONE_W : WRITE;
        end else if (pend_pop) begin
          do_pop    = 1'b1;
          state_nxt = is_empty ? DONE_R : READ;
        end
      end
      WRITE:   if (wr_done) state_nxt = DONE_W;
      READ:    if (rd_done) state_nxt = DONE_R;
      DONE_W:  state_nxt = IDLE;
      DONE_R:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rollback wins over commit; open is applied on top of either result.
  always_comb begin
    wr_ptr_ctrl = wr_ptr;
    wr_tmp_ctrl = wr_tmp;
    if (pend_rollback)    wr_tmp_ctrl = wr_ptr;
    else if (pend_commit) wr_ptr_ctrl = wr_tmp;
    if (pend_open)        wr_tmp_ctrl = wr_ptr_ctrl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      wr_tmp        <= '0;
      pend_push     <= 1'b0;
      pend_pop      <= 1'b0;
      pend_open     <= 1'b0;
      pend_commit   <= 1'b0;
      pend_rollback <= 1'b0;
      push_buf      <= '0;
      wr_data_q     <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pop_data_q    <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      // A fresh request on the service edge re-arms the pending bit.
      pend_push     <= (pend_push & ~do_push) | push_request;
      pend_pop      <= (pend_pop & ~do_pop) | pop_request;
      pend_open     <= (pend_open & ~do_ctrl) | open;
      pend_commit   <= (pend_commit & ~do_ctrl) | commit;
      pend_rollback <= (pend_rollback & ~do_ctrl) | rollback;
      if (push_request) push_buf <= push_data;

      if (do_ctrl) begin
        wr_ptr <= wr_ptr_ctrl;
        wr_tmp <= wr_tmp_ctrl;
        if (pend_open) overflow_q <= 1'b0;
      end

      if (do_push) begin
        if (is_full) begin
          overflow_q <= 1'b1;
        end else begin
          wr_addr_q <= wr_tmp[ADDRW-1:0];
          wr_data_q <= push_buf;
        end
      end
      if (state == WRITE && wr_done) wr_tmp <= wr_tmp + ONE;

      if (do_pop) begin
        if (is_empty) begin
          pop_data_q  <= '0;
          underflow_q <= 1'b1;
        end else begin
          rd_addr_q <= rd_ptr[ADDRW-1:0];
        end
      end
      if (state == READ && rd_done) begin
        pop_data_q <= rd_data;
        rd_ptr     <= rd_ptr + ONE;
      end
    end
  end

  assign wr_request = (state == WRITE);
  assign rd_request = (state == READ);
  assign push_done  = (state == DONE_W);
  assign pop_done   = (state == DONE_R);
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = rd_addr_q;
  assign pop_data   = pop_data_q;
  assign count      = wr_ptr - rd_ptr;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
